// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - fetch stage and IF/ID pipeline register with EXEC detour (optional perf counters: IF_PERF_CNT_EN)
module if_id_stage #(
    parameter int              ISIZE  = 16,
    parameter int              RSIZE  = 4,
    parameter int              PCW    = 16,
    parameter logic [PCW-1:0]  RST_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               Stall,
    input  logic               Redirect,
    input  logic [PCW-1:0]     RedirectPC,
    input  logic               ExecReq,
    input  logic [PCW-1:0]     ExecPC,
    input  logic [ISIZE-1:0]   IMemData,
    output logic [PCW-1:0]     IMemAddr,
    output logic [ISIZE-1:0]   InstrD,
    output logic [PCW-1:0]     PCPlus1D,
    output logic               ValidD,
    output logic [3:0]         OpCode,
    output logic [2:0]         Cond,
    output logic [RSIZE-1:0]   AddrRs,
    output logic [RSIZE-1:0]   AddrRt,
    output logic [ISIZE-1:0]   LastInstr,
`ifdef IF_PERF_CNT_EN
    output logic [15:0]        StallCnt,
    output logic [15:0]        FlushCnt,
    output logic [15:0]        ExecCnt,
`endif
    output logic [3:0]         EXECTest
);

    typedef enum logic {
        RUN    = 1'b0,
        EXEC_F = 1'b1
    } state_t;

    localparam logic [PCW-1:0] PC_ONE = {{(PCW-1){1'b0}}, 1'b1};

    state_t             state;
    state_t             state_next;
    logic [PCW-1:0]     pc;
    logic [PCW-1:0]     ret_pc;
    logic               exec_flag;

    // Per-edge action, exactly one is active: redirect > accepted exec > stall > advance
    logic               do_redirect;
    logic               do_exec;
    logic               do_stall;
    logic               do_advance;

    // FSM state register; reset abandons any detour in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state: redirect always lands in RUN, a nested exec request is ignored
    always_comb begin
        state_next = state;
        if (Redirect) begin
            state_next = RUN;
        end else if (ExecReq && (state == RUN)) begin
            state_next = EXEC_F;
        end else if (Stall) begin
            state_next = state;
        end else begin
            state_next = RUN;
        end
    end

    // FSM outputs: decode the single action taken at the coming edge
    always_comb begin
        do_redirect = 1'b0;
        do_exec     = 1'b0;
        do_stall    = 1'b0;
        do_advance  = 1'b0;
        if (Redirect) begin
            do_redirect = 1'b1;
        end else if (ExecReq && (state == RUN)) begin
            do_exec = 1'b1;
        end else if (Stall) begin
            do_stall = 1'b1;
        end else begin
            do_advance = 1'b1;
        end
    end

    // PC, return PC and IF/ID register update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= RST_PC;
            ret_pc    <= '0;
            InstrD    <= '0;
            PCPlus1D  <= '0;
            ValidD    <= 1'b0;
            exec_flag <= 1'b0;
            LastInstr <= '0;
        end else if (do_redirect) begin
            // The branch itself moves into EX; the wrong-path fetch becomes a bubble
            pc        <= RedirectPC;
            InstrD    <= '0;
            ValidD    <= 1'b0;
            exec_flag <= 1'b0;
            LastInstr <= InstrD;
        end else if (do_exec) begin
            // Remember where to come back to once the single target word is fetched
            ret_pc    <= pc;
            pc        <= ExecPC;
            InstrD    <= '0;
            ValidD    <= 1'b0;
            exec_flag <= 1'b0;
            LastInstr <= InstrD;
        end else if (do_stall) begin
            // ID holds, so EX receives a bubble
            LastInstr <= '0;
        end else if (do_advance) begin
            InstrD    <= IMemData;
            PCPlus1D  <= pc + PC_ONE;
            ValidD    <= 1'b1;
            exec_flag <= (state == EXEC_F);
            pc        <= (state == EXEC_F) ? ret_pc : (pc + PC_ONE);
            LastInstr <= ValidD ? InstrD : '0;
        end
    end

`ifdef IF_PERF_CNT_EN
    // Saturating event counters, one increment per edge following the action priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            StallCnt <= '0;
            FlushCnt <= '0;
            ExecCnt  <= '0;
        end else begin
            if (do_stall && (StallCnt != 16'hFFFF)) begin
                StallCnt <= StallCnt + 16'd1;
            end
            if (do_redirect && (FlushCnt != 16'hFFFF)) begin
                FlushCnt <= FlushCnt + 16'd1;
            end
            if (do_exec && (ExecCnt != 16'hFFFF)) begin
                ExecCnt <= ExecCnt + 16'd1;
            end
        end
    end
`endif

    // Fetch address and pre-split decode fields
    always_comb begin
        IMemAddr = pc;
        OpCode   = InstrD[15:12];
        Cond     = InstrD[11:9];
        AddrRs   = InstrD[2*RSIZE-1:RSIZE];
        AddrRt   = InstrD[RSIZE-1:0];
        EXECTest = exec_flag ? InstrD[15:12] : 4'h0;
    end

endmodule

// File: tb/tb_if_id_stage.sv
// tb/tb_if_id_stage.sv - randomized self-checking bench for if_id_stage against a behavioural model
module tb_if_id_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        Stall, Redirect, ExecReq;
    logic [15:0] RedirectPC, ExecPC;
    logic [15:0] IMemData, IMemAddr, InstrD, PCPlus1D, LastInstr;
    logic        ValidD;
    logic [3:0]  OpCode, EXECTest;
    logic [2:0]  Cond;
    logic [3:0]  AddrRs, AddrRt;
`ifdef IF_PERF_CNT_EN
    logic [15:0] StallCnt, FlushCnt, ExecCnt;
`endif

    logic [15:0] mem [0:65535];
    assign IMemData = mem[IMemAddr];

    if_id_stage dut (
        .clk(clk), .rst_n(rst_n), .Stall(Stall), .Redirect(Redirect), .RedirectPC(RedirectPC),
        .ExecReq(ExecReq), .ExecPC(ExecPC), .IMemData(IMemData), .IMemAddr(IMemAddr),
        .InstrD(InstrD), .PCPlus1D(PCPlus1D), .ValidD(ValidD), .OpCode(OpCode), .Cond(Cond),
        .AddrRs(AddrRs), .AddrRt(AddrRt), .LastInstr(LastInstr),
`ifdef IF_PERF_CNT_EN
        .StallCnt(StallCnt), .FlushCnt(FlushCnt), .ExecCnt(ExecCnt),
`endif
        .EXECTest(EXECTest)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: the architectural view of the fetch stage
    logic [15:0] m_pc, m_ret, m_instr, m_p1, m_last;
    logic        m_valid, m_detour, m_from_exec;
    int          m_stalls, m_flushes, m_execs;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc = 16'h0; m_ret = 16'h0; m_instr = 16'h0; m_p1 = 16'h0; m_last = 16'h0;
            m_valid = 1'b0; m_detour = 1'b0; m_from_exec = 1'b0;
            m_stalls = 0; m_flushes = 0; m_execs = 0;
        end else if (Redirect) begin
            m_last = m_instr; m_instr = 16'h0; m_valid = 1'b0; m_from_exec = 1'b0;
            m_pc = RedirectPC; m_detour = 1'b0;
            if (m_flushes < 65535) m_flushes++;
        end else if (ExecReq && !m_detour) begin
            m_last = m_instr; m_instr = 16'h0; m_valid = 1'b0; m_from_exec = 1'b0;
            m_ret = m_pc; m_pc = ExecPC; m_detour = 1'b1;
            if (m_execs < 65535) m_execs++;
        end else if (Stall) begin
            m_last = 16'h0;
            if (m_stalls < 65535) m_stalls++;
        end else begin
            m_last = m_valid ? m_instr : 16'h0;
            m_instr = mem[m_pc];
            m_valid = 1'b1;
            m_p1 = 16'((32'(m_pc) + 1) % 65536);
            m_from_exec = m_detour;
            m_pc = m_detour ? m_ret : 16'((32'(m_pc) + 1) % 65536);
            m_detour = 1'b0;
        end
    end

    // Per-cycle comparison against the model
    always @(posedge clk) begin
        #1;
        if (rst_n && chk_en) begin
            chk("IMemAddr", IMemAddr, m_pc);
            chk("ValidD", ValidD, m_valid);
            chk("InstrD", InstrD, m_instr);
            chk("LastInstr", LastInstr, m_last);
            chk("OpCode", OpCode, m_instr / 4096);
            chk("Cond", Cond, (m_instr / 512) % 8);
            chk("AddrRs", AddrRs, (m_instr / 16) % 16);
            chk("AddrRt", AddrRt, m_instr % 16);
            chk("EXECTest", EXECTest, m_from_exec ? m_instr / 4096 : 0);
            if (m_valid) chk("PCPlus1D", PCPlus1D, m_p1);
`ifdef IF_PERF_CNT_EN
            chk("StallCnt", StallCnt, m_stalls);
            chk("FlushCnt", FlushCnt, m_flushes);
            chk("ExecCnt", ExecCnt, m_execs);
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0; Stall = 1'b0; Redirect = 1'b0; ExecReq = 1'b0;
        RedirectPC = 16'h0; ExecPC = 16'h0;
        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
        mem[0] = 16'h0123; mem[1] = 16'h1456; mem[2] = 16'h2789;
        mem[16'h20] = 16'h3abc; mem[16'h30] = 16'hF000;
        step(); step();
        chk("reset IMemAddr", IMemAddr, 16'h0);
        chk("reset ValidD", ValidD, 1'b0);
        chk("reset InstrD", InstrD, 16'h0);
        rst_n = 1'b1; chk_en = 1'b1;

        // Sequential fetch
        step();
        chk("seq InstrD", InstrD, 16'h0123);
        chk("seq OpCode", OpCode, 4'h0);
        chk("seq AddrRs", AddrRs, 4'h2);
        chk("seq AddrRt", AddrRt, 4'h3);
        chk("seq PCPlus1D", PCPlus1D, 16'h1);
        step();
        chk("seq LastInstr", LastInstr, 16'h0123);

        // Redirect beats stall
        Redirect = 1'b1; RedirectPC = 16'h0040; Stall = 1'b1;
        step();
        Redirect = 1'b0; Stall = 1'b0;
        chk("redir IMemAddr", IMemAddr, 16'h0040);
        chk("redir ValidD", ValidD, 1'b0);

        // Stall three edges at PC=5
        Redirect = 1'b1; RedirectPC = 16'h0004;
        step();
        Redirect = 1'b0;
        step();
        Stall = 1'b1;
        step();
        chk("stall IMemAddr", IMemAddr, 16'h0005);
        chk("stall InstrD", InstrD, mem[4]);
        chk("stall LastInstr", LastInstr, 16'h0);
        step(); step();
        chk("stall3 IMemAddr", IMemAddr, 16'h0005);
        chk("stall3 InstrD", InstrD, mem[4]);
`ifdef IF_PERF_CNT_EN
        chk("lit StallCnt", StallCnt, 16'd3);
`endif
        Stall = 1'b0;
        step();
        chk("resume IMemAddr", IMemAddr, 16'h0006);

        // EXEC detour from PC=8
        Redirect = 1'b1; RedirectPC = 16'h0008;
        step();
        Redirect = 1'b0; ExecReq = 1'b1; ExecPC = 16'h0020;
        step();
        ExecReq = 1'b0;
        chk("exec bubble", ValidD, 1'b0);
        chk("exec IMemAddr", IMemAddr, 16'h0020);
        step();
        chk("exec InstrD", InstrD, 16'h3abc);
        chk("exec EXECTest", EXECTest, 4'h3);
        chk("exec return", IMemAddr, 16'h0008);
        step();
        chk("post EXECTest", EXECTest, 4'h0);
        chk("post IMemAddr", IMemAddr, 16'h0009);

        // Nested EXEC is ignored; detour word F000 flags itself
        ExecReq = 1'b1; ExecPC = 16'h0030;
        step();
        ExecPC = 16'h0050;
        step();
        ExecReq = 1'b0;
        chk("nest InstrD", InstrD, 16'hF000);
        chk("nest EXECTest", EXECTest, 4'hf);
        chk("nest return", IMemAddr, 16'h0009);
`ifdef IF_PERF_CNT_EN
        chk("lit ExecCnt", ExecCnt, 16'd2);
        chk("lit FlushCnt", FlushCnt, 16'd3);
`endif

        // PC wrap
        Redirect = 1'b1; RedirectPC = 16'hFFFF;
        step();
        Redirect = 1'b0;
        step();
        chk("wrap IMemAddr", IMemAddr, 16'h0000);
        chk("wrap PCPlus1D", PCPlus1D, 16'h0000);

        // Asynchronous reset mid-cycle
        rst_n = 1'b0;
        #1;
        chk("async IMemAddr", IMemAddr, 16'h0);
        chk("async InstrD", InstrD, 16'h0);
        chk("async ValidD", ValidD, 1'b0);
        chk("async LastInstr", LastInstr, 16'h0);
        step();
        rst_n = 1'b1;

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            Stall      = ($urandom_range(0, 3) == 0);
            Redirect   = ($urandom_range(0, 9) == 0);
            ExecReq    = ($urandom_range(0, 7) == 0);
            RedirectPC = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom);
            ExecPC     = 16'($urandom);
            mem[16'($urandom)] = 16'($urandom);
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
            end else begin
                step();
            end
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
